// File: rtl/mc_control_fsm.sv
// Multicycle main controller for the unpipelined MIPS core.
// Sequences fetch/decode/execute/memory/writeback, drives datapath enables
// and mux selects, supervises memory wait states with a timeout, and obeys
// run/idle control at instruction boundaries.
// Optional build macro: MC_CTRL_PERF_EN adds instr_count / cycle_count.
module mc_control_fsm #(
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       bus_err
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
`endif
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    I_EXEC   = 4'd11,
    I_WB     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            mem_state;
  logic            timeout;
  state_t          boundary_next;

  // Next-state, sticky flags and wait-state counter.
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    mem_state     = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    // The limit only bites if memory is still not ready on that cycle.
    timeout       = mem_state && !mem_ready && (wait_q == TO_LIMIT);
    boundary_next = run ? FETCH : IDLE;

    case (state_q)
      IDLE:     if (run && !bus_err_q) state_d = FETCH;
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = R_EXEC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = I_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = boundary_next;
          end
        endcase
      end
      MEM_ADDR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WB:   state_d = boundary_next;
      MEM_WR:   if (mem_ready) state_d = boundary_next;
      R_EXEC:   state_d = R_WB;
      R_WB:     state_d = boundary_next;
      BRANCH:   state_d = boundary_next;
      JUMP:     state_d = boundary_next;
      I_EXEC:   state_d = I_WB;
      I_WB:     state_d = boundary_next;
      default:  state_d = IDLE;
    endcase

    if (timeout) begin
      state_d   = IDLE;
      bus_err_d = 1'b1;
    end

    // Counting only while parked in a memory state; any transition clears,
    // which covers entry into FETCH, MEM_RD and MEM_WR.
    wait_d = (mem_state && (state_d == state_q)) ? wait_q + 1'b1 : '0;
  end

  // State, flag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
    end
  end

  // Moore outputs from state; FETCH loads IR/PC only when memory is ready,
  // and a timeout cycle suppresses every enable.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    if (!timeout) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = 2'b11;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        I_WB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign bus_err    = bus_err_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_q, instr_d;
  logic [31:0] cycle_q, cycle_d;
  logic        instr_done;

  // Performance counters: busy cycles and completed (legal) instructions.
  always_comb begin
    instr_done = !timeout &&
                 ((state_q == MEM_WB) || (state_q == R_WB) || (state_q == I_WB) ||
                  (state_q == BRANCH) || (state_q == JUMP) ||
                  ((state_q == MEM_WR) && mem_ready));
    instr_d = instr_done ? instr_q + 32'd1 : instr_q;
    cycle_d = (state_q != IDLE) ? cycle_q + 32'd1 : cycle_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      instr_q <= instr_d;
      cycle_q <= cycle_d;
    end
  end

  assign instr_count = instr_q;
  assign cycle_count = cycle_q;
`endif

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main controller for the unpipelined MIPS core: sequences fetch/decode/execute/memory/writeback over shared ALU, register file and unified memory.
- Emits ALUOp (00 add, 01 subtract, 10 R-type funct decode) to the ALU control decoder, plus all datapath enables and mux selects.
- Implements a ready handshake with memory, a wait-state timeout, and run/idle control.

Parameters:
- TO_W, 4, width of the memory wait-state counter.
- MEM_TIMEOUT, 15, max consecutive cycles in a memory state with mem_ready low before bus error (must be < 2^TO_W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level: 1 = execute instructions, 0 = stop at next instruction boundary
- opcode  in  6  IR[31:26]
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback select: 1 = MDR
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 regB, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate
- alu_op  out  2  to ALU control decoder
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- state  out  4  current state encoding
- illegal_op  out  1  sticky: undecodable opcode seen
- bus_err  out  1  sticky: memory timeout

Behaviour:
- State encoding (4 b): IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.
- Reset: state = IDLE; illegal_op = bus_err = 0; wait counter = 0. All outputs are 0 in IDLE.
- Outputs are Moore from state, except ir_write and pc_write in FETCH, which are qualified by mem_ready.
- IDLE -> FETCH when run = 1.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - Holds while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 for that cycle, then -> DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 (lw) -> MEM_ADDR
  - 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> I_EXEC
  - other -> set illegal_op, go to the instruction-boundary decision
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: MEM_RD if lw, MEM_WR if sw.
- MEM_RD: mem_read = 1, i_or_d = 1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
- MEM_WR: mem_write = 1, i_or_d = 1. Holds until mem_ready, then completes.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> R_WB. R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> I_WB. I_WB: reg_write = 1, reg_dst = 0.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01.
- JUMP: pc_write = 1, pc_source = 10.
- Instruction boundary: after MEM_WB, MEM_WR completion, R_WB, I_WB, BRANCH, JUMP or an illegal decode, next state is FETCH if run = 1, else IDLE. Dropping run mid-instruction never aborts it.
- Latencies with zero wait states: lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle in those states while mem_ready = 0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: set bus_err, go to IDLE, assert no enables that cycle.
  - mem_ready = 1 on the same cycle as the limit wins: the access completes.
- While bus_err = 1, IDLE does not leave. Only reset clears illegal_op and bus_err.
- Asynchronous reset mid-instruction returns to IDLE immediately. No partial write enable may remain asserted.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- When defined, adds outputs instr_count (32 b) and cycle_count (32 b), both reset to 0:
  - cycle_count increments every cycle state != IDLE.
  - instr_count increments on each instruction-boundary transition, excluding illegal decodes.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, neither port nor counter logic exists.

Test Plan:
- Reset, run = 1, mem_ready tied 1, opcode 000000 -> states 1, 2, 7, 8, 1. alu_op = 10 in R_EXEC; reg_write = 1 and reg_dst = 1 only in R_WB.
- lw (100011) with mem_ready low 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles. Exactly one cycle of reg_write with mem_to_reg = 1. Total 8 cycles FETCH to FETCH.
- beq (000100) -> BRANCH asserts pc_write_cond = 1, alu_op = 01, pc_source = 01 for one cycle. j (000010) -> pc_write = 1, pc_source = 10.
- Opcode 111111 -> illegal_op = 1 after DECODE, next state FETCH, no reg_write/mem_write. Flag persists until rst_n low.
- mem_ready held 0 in FETCH -> after 15 wait cycles bus_err = 1, state = 0, stays 0 with run = 1. Mid-run async reset returns state 0 with all outputs 0 within the same cycle.
- run dropped during MEM_ADDR of sw -> MEM_WR completes, then state = IDLE. Raising run resumes at FETCH.
